mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage of the vector ASIP pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs: rmem, wmem, wreg, ALU result, store data, destination and vector flag.
- Scalar accesses are a single 32-bit beat. Vector accesses are split into 4 sequential 32-bit beats on a synchronous data RAM. The block stalls upstream stages while beats are outstanding.
- Results feed the MEM/WB register through registered outputs.

Parameters:
- ADDR_W, 16, word-address width of the data RAM port; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rmem  in  1  load request.
- wmem  in  1  store request.
- wreg  in  1  register write-back enable.
- alu_res  in  128  ALU result; bits [ADDR_W-1:0] form the base word address.
- st_data  in  128  store data.
- dest  in  4  destination register index.
- vf  in  1  1 = vector (4 beats), 0 = scalar (1 beat).
- mem_addr  out  ADDR_W  RAM word address.
- mem_re  out  1  RAM read enable; data returns on mem_rdata the next cycle.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.
- stall  out  1  hold EX/MEM and upstream stages.
- wb_wreg  out  1  registered write-back enable.
- wb_data  out  128  registered write-back data.
- wb_dest  out  4  registered destination index.
- wb_vf  out  1  registered vector flag.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; beat counter, lane buffer and all outputs go to 0.
  - Reset mid-operation aborts all remaining beats; no further mem_re/mem_we pulses.
- Beat/lane mapping: beat k uses address (base+k) mod 2^ADDR_W and lane bits [32k+31:32k]. N = 4 if vf, else 1.
- States: IDLE, LOAD, STORE.
- IDLE, no memory op:
  - wb_* <= {wreg, alu_res, dest, vf} at the next edge.
  - stall = 0; state stays IDLE.
- IDLE with rmem:
  - Drive mem_re = 1, mem_addr = base, stall = 1.
  - Latch base, dest, wreg, vf; go to LOAD with beat = 1; wb_wreg <= 0 (bubble).
  - If rmem and wmem are both set, the load wins and no write is issued.
- LOAD, each cycle:
  - Capture mem_rdata into lane (beat-1).
  - If beat < N: issue the read at base+beat, beat++, stall = 1.
  - If beat == N: stall = 0; wb_* <= {latched wreg, assembled buffer, dest, vf}; return to IDLE; inputs are ignored this cycle.
  - Scalar load result is zero-extended in bits [127:32].
  - Load stall length is N cycles; wb_* are valid N+1 cycles after acceptance.
- IDLE with wmem:
  - Drive mem_we = 1, mem_addr = base, mem_wdata = st_data[31:0]; wb_wreg <= 0.
  - Scalar store: done in one cycle, stall = 0.
  - Vector store: latch st_data and base, go to STORE with beat = 1, stall = 1.
- STORE, each cycle:
  - Write lane beat at base+beat; stall = (beat < 3).
  - Return to IDLE after beat 3. Vector store stalls for 3 cycles.
- Stores never assert wb_wreg.
- mem_re and mem_we are never asserted in the same cycle.
- Outside an issuing cycle, mem_re, mem_we, mem_addr and mem_wdata are 0.

Optional Feature:
- MEM_STALL_CNT_EN:
  - Defined: adds output port stall_cnt [31:0]. It increments on every cycle with stall = 1, saturates at 0xFFFFFFFF, and resets to 0 on rst.
  - Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg holds:
  - the state enum (IDLE, LOAD, STORE);
  - LANES = 4, WORD_W = 32, VEC_W = 128;
  - the default ADDR_W.
- Sub-module vec_lane_buffer: 128-bit assembly register with a 2-bit lane select, a write strobe, and clear on rst.
- The FSM, beat counter and memory-port muxing stay in the top level.

Test Plan:
- ALU op, wreg = 1, alu_res = 0x1234, dest = 5, vf = 0 -> stall stays 0; next cycle wb_wreg = 1, wb_data = 0x1234, wb_dest = 5; no mem_re/mem_we.
- Scalar load, base 0x0010, RAM[0x10] = 0xDEADBEEF -> mem_re for 1 cycle, stall for 1 cycle; wb_data = 0x...00DEADBEEF (zero-extended) two cycles after issue.
- Vector load, base 0xFFFE, RAM[FFFE, FFFF, 0000, 0001] = 1, 2, 3, 4 -> addresses wrap; stall for 4 cycles; wb_data = 0x00000004_00000003_00000002_00000001, wb_vf = 1.
- Vector store, st_data = 0xA..D lanes, base 0x20 -> mem_we at 0x20..0x23 with lanes 0..3 on consecutive cycles; stall for 3 cycles; wb_wreg = 0.
- rst asserted in the 2nd beat of a vector load -> outputs 0 immediately; no further mem_re; after release, an ALU op completes normally.
- rmem = wmem = 1, scalar -> behaves as a load; mem_we never asserted.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the vector ASIP memory stage.
// Holds the FSM state encoding, lane geometry and the default RAM address width.
// Imported by the interface, the lane buffer and the top level.
package mem_access_pkg;

    localparam int LANES      = 4;
    localparam int WORD_W     = 32;
    localparam int VEC_W      = 128;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle between the EX/MEM register, the data RAM, the MEM/WB register and the memory stage.
// slave = memory stage view, master = surrounding pipeline/RAM view.
// stall_cnt exists only when MEM_STALL_CNT_EN is defined.
interface mem_access_unit_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              rmem;
    logic              wmem;
    logic              wreg;
    logic [VEC_W-1:0]  alu_res;
    logic [VEC_W-1:0]  st_data;
    logic [3:0]        dest;
    logic              vf;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              stall;
    logic              wb_wreg;
    logic [VEC_W-1:0]  wb_data;
    logic [3:0]        wb_dest;
    logic              wb_vf;
`ifdef MEM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    modport slave (
        input  rmem, wmem, wreg, alu_res, st_data, dest, vf, mem_rdata,
`ifdef MEM_STALL_CNT_EN
        output stall_cnt,
`endif
        output mem_addr, mem_re, mem_we, mem_wdata, stall,
        output wb_wreg, wb_data, wb_dest, wb_vf
    );

    modport master (
        output rmem, wmem, wreg, alu_res, st_data, dest, vf, mem_rdata,
`ifdef MEM_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  mem_addr, mem_re, mem_we, mem_wdata, stall,
        input  wb_wreg, wb_data, wb_dest, wb_vf
    );

endinterface

// File: rtl/mem_access_unit_vec_lane_buffer.sv
// 128-bit load assembly register, written one 32-bit lane at a time.
// Latency: a lane write is visible on buf_o the cycle after the strobe.
// No backpressure; clr_i has priority over wr_i.
module vec_lane_buffer
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [1:0]        sel_i,
    input  logic [WORD_W-1:0] wdat_i,
    output logic [VEC_W-1:0]  buf_o
);

    logic [VEC_W-1:0] buf_q;
    logic [VEC_W-1:0] buf_d;

    // Clear for a new load, otherwise drop the incoming word into its lane
    always_comb begin
        buf_d = buf_q;
        if (clr_i) begin
            buf_d = '0;
        end else if (wr_i) begin
            buf_d[WORD_W*sel_i +: WORD_W] = wdat_i;
        end
    end

    // Assembly register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_o = buf_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: scalar 1-beat / vector 4-beat loads and stores on a 32-bit synchronous RAM.
// Latency: ALU and scalar store 1 cycle, vector store 4, load N+1 to wb_*; stall held while beats remain.
// Optional MEM_STALL_CNT_EN adds a saturating count of stalled cycles on stall_cnt.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    mau_state_t        state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        dest_q, dest_d;
    logic              wreg_q, wreg_d;
    logic              vf_q, vf_d;
    logic [VEC_W-1:0]  st_data_q, st_data_d;

    logic              wb_wreg_q, wb_wreg_d;
    logic [VEC_W-1:0]  wb_data_q, wb_data_d;
    logic [3:0]        wb_dest_q, wb_dest_d;
    logic              wb_vf_q, wb_vf_d;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic              stall;

    logic              lb_clr;
    logic              lb_wr;
    logic [1:0]        lb_sel;
    logic [VEC_W-1:0]  lb_buf;
    logic [VEC_W-1:0]  load_vec;

    logic [ADDR_W-1:0] in_base;
    logic [2:0]        n_beats;

    assign in_base = bus.alu_res[ADDR_W-1:0];
    assign n_beats = vf_q ? 3'(LANES) : 3'd1;

    vec_lane_buffer u_lane_buf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lb_clr),
        .wr_i   (lb_wr),
        .sel_i  (lb_sel),
        .wdat_i (bus.mem_rdata),
        .buf_o  (lb_buf)
    );

    // Final load beat: the last word is still on mem_rdata, so merge it in front of the buffer
    always_comb begin
        load_vec = lb_buf;
        load_vec[WORD_W*lb_sel +: WORD_W] = bus.mem_rdata;
    end

    // Next state, beat sequencing and memory-port muxing
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        dest_d    = dest_q;
        wreg_d    = wreg_q;
        vf_d      = vf_q;
        st_data_d = st_data_q;
        wb_wreg_d = wb_wreg_q;
        wb_data_d = wb_data_q;
        wb_dest_d = wb_dest_q;
        wb_vf_d   = wb_vf_q;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        stall     = 1'b0;
        lb_clr    = 1'b0;
        lb_wr     = 1'b0;
        lb_sel    = beat_q[1:0] - 2'd1;

        unique case (state_q)
            IDLE: begin
                if (bus.rmem) begin
                    // Load wins over a simultaneous store request
                    mem_re    = 1'b1;
                    mem_addr  = in_base;
                    stall     = 1'b1;
                    base_d    = in_base;
                    dest_d    = bus.dest;
                    wreg_d    = bus.wreg;
                    vf_d      = bus.vf;
                    beat_d    = 3'd1;
                    wb_wreg_d = 1'b0;
                    lb_clr    = 1'b1;
                    state_d   = LOAD;
                end else if (bus.wmem) begin
                    mem_we    = 1'b1;
                    mem_addr  = in_base;
                    mem_wdata = bus.st_data[WORD_W-1:0];
                    wb_wreg_d = 1'b0;
                    if (bus.vf) begin
                        stall     = 1'b1;
                        base_d    = in_base;
                        st_data_d = bus.st_data;
                        beat_d    = 3'd1;
                        state_d   = STORE;
                    end
                end else begin
                    wb_wreg_d = bus.wreg;
                    wb_data_d = bus.alu_res;
                    wb_dest_d = bus.dest;
                    wb_vf_d   = bus.vf;
                end
            end
            LOAD: begin
                lb_wr = 1'b1;
                if (beat_q < n_beats) begin
                    mem_re   = 1'b1;
                    mem_addr = base_q + ADDR_W'(beat_q);
                    stall    = 1'b1;
                    beat_d   = beat_q + 3'd1;
                end else begin
                    wb_wreg_d = wreg_q;
                    wb_data_d = load_vec;
                    wb_dest_d = dest_q;
                    wb_vf_d   = vf_q;
                    beat_d    = 3'd0;
                    state_d   = IDLE;
                end
            end
            STORE: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(beat_q);
                mem_wdata = st_data_q[WORD_W*beat_q[1:0] +: WORD_W];
                stall     = (beat_q < 3'(LANES - 1));
                if (beat_q == 3'(LANES - 1)) begin
                    beat_d  = 3'd0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end
        endcase

        // Reset silences the RAM port and stall immediately, not just at the next edge
        if (rst) begin
            mem_addr  = '0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            stall     = 1'b0;
        end
    end

    // State, latched operands and write-back registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            dest_q    <= '0;
            wreg_q    <= 1'b0;
            vf_q      <= 1'b0;
            st_data_q <= '0;
            wb_wreg_q <= 1'b0;
            wb_data_q <= '0;
            wb_dest_q <= '0;
            wb_vf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            dest_q    <= dest_d;
            wreg_q    <= wreg_d;
            vf_q      <= vf_d;
            st_data_q <= st_data_d;
            wb_wreg_q <= wb_wreg_d;
            wb_data_q <= wb_data_d;
            wb_dest_q <= wb_dest_d;
            wb_vf_q   <= wb_vf_d;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall-cycle count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.stall     = stall;
    assign bus.wb_wreg   = wb_wreg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_vf     = wb_vf_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then randomized ops against an operation-level model.
// The RAM is modelled in the stimulus process; a separate shadow array predicts load results.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_access_unit;

    logic clk;
    logic rst;

    mem_access_unit_if #(.ADDR_W(16)) bus ();

    mem_access_unit #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] ram     [65536];
    logic [31:0] ref_mem [65536];
    logic [31:0] rd_pend;
    int unsigned exp_cnt = 0;

    logic         e_wreg;
    logic [127:0] e_data;
    logic [3:0]   e_dest;
    logic         e_vf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM reacts to what the DUT drives this cycle; read data appears next cycle
    task automatic ram_act();
        rd_pend = 32'h0;
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re === 1'b1) rd_pend = ram[bus.mem_addr];
    endtask

    task automatic next_cycle();
        ram_act();
        @(posedge clk);
        #1;
        bus.mem_rdata = rd_pend;
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // One instruction held on the inputs for as long as it occupies the stage
    task automatic run_op(input string nm, input logic rm, input logic wm, input logic wr,
                          input logic [127:0] alu, input logic [127:0] sd,
                          input logic [3:0] d, input logic v);
        int           n;
        int           ncyc;
        bit           is_ld;
        bit           is_st;
        logic [15:0]  base;
        logic [127:0] ld;
        is_ld = rm;
        is_st = !rm && wm;
        n     = v ? 4 : 1;
        ncyc  = is_ld ? n + 1 : (is_st ? n : 1);
        base  = alu[15:0];
        bus.rmem    = rm;
        bus.wmem    = wm;
        bus.wreg    = wr;
        bus.alu_res = alu;
        bus.st_data = sd;
        bus.dest    = d;
        bus.vf      = v;
        for (int c = 0; c < ncyc; c++) begin
            logic        x_re, x_we, x_st;
            logic [15:0] x_a;
            logic [31:0] x_wd;
            x_re = is_ld && (c < n);
            x_we = is_st && (c < n);
            x_a  = (x_re || x_we) ? base + 16'(c) : 16'h0;
            x_wd = 32'h0;
            if (x_we) x_wd = sd[32*c +: 32];
            x_st = is_ld ? (c < n) : (is_st ? (c < n - 1) : 1'b0);
            @(negedge clk);
            chk({nm, "/stall"},  128'(bus.stall),     128'(x_st));
            chk({nm, "/re"},     128'(bus.mem_re),    128'(x_re));
            chk({nm, "/we"},     128'(bus.mem_we),    128'(x_we));
            chk({nm, "/addr"},   128'(bus.mem_addr),  128'(x_a));
            chk({nm, "/wdata"},  128'(bus.mem_wdata), 128'(x_wd));
            if (x_st) exp_cnt++;
            next_cycle();
        end
        if (is_st) begin
            for (int k = 0; k < n; k++) ref_mem[base + 16'(k)] = sd[32*k +: 32];
            e_wreg = 1'b0;
        end else if (is_ld) begin
            ld = '0;
            for (int k = 0; k < n; k++) ld[32*k +: 32] = ref_mem[base + 16'(k)];
            e_wreg = wr;
            e_data = ld;
            e_dest = d;
            e_vf   = v;
        end else begin
            e_wreg = wr;
            e_data = alu;
            e_dest = d;
            e_vf   = v;
        end
        chk({nm, "/wb_wreg"}, 128'(bus.wb_wreg), 128'(e_wreg));
        if (!is_st) begin
            chk({nm, "/wb_data"}, bus.wb_data,       e_data);
            chk({nm, "/wb_dest"}, 128'(bus.wb_dest), 128'(e_dest));
            chk({nm, "/wb_vf"},   128'(bus.wb_vf),   128'(e_vf));
        end
`ifdef MEM_STALL_CNT_EN
        chk({nm, "/stall_cnt"}, 128'(bus.stall_cnt), 128'(exp_cnt));
`endif
    endtask

    initial begin
        logic [127:0] r_alu;
        logic [127:0] r_sd;
        int           kind;

        for (int i = 0; i < 65536; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        rst           = 1'b1;
        bus.rmem      = 1'b0;
        bus.wmem      = 1'b0;
        bus.wreg      = 1'b0;
        bus.alu_res   = '0;
        bus.st_data   = '0;
        bus.dest      = '0;
        bus.vf        = 1'b0;
        bus.mem_rdata = '0;
        e_wreg = 1'b0;
        e_data = '0;
        e_dest = '0;
        e_vf   = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst/stall",   128'(bus.stall),   128'(0));
        chk("rst/re",      128'(bus.mem_re),  128'(0));
        chk("rst/we",      128'(bus.mem_we),  128'(0));
        chk("rst/wb_wreg", 128'(bus.wb_wreg), 128'(0));
        chk("rst/wb_data", bus.wb_data,       128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed scenarios
        run_op("alu", 1'b0, 1'b0, 1'b1, 128'h1234, 128'h0, 4'd5, 1'b0);
        poke(16'h0010, 32'hDEAD_BEEF);
        run_op("sld", 1'b1, 1'b0, 1'b1, 128'h0010, 128'h0, 4'd3, 1'b0);
        chk("sld/zext", bus.wb_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        poke(16'hFFFE, 32'd1);
        poke(16'hFFFF, 32'd2);
        poke(16'h0000, 32'd3);
        poke(16'h0001, 32'd4);
        run_op("vld_wrap", 1'b1, 1'b0, 1'b1, 128'hFFFE, 128'h0, 4'd9, 1'b1);
        chk("vld_wrap/data", bus.wb_data, 128'h0000_0004_0000_0003_0000_0002_0000_0001);
        run_op("vst", 1'b0, 1'b1, 1'b1, 128'h0020,
               128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 4'd2, 1'b1);
        run_op("vld_back", 1'b1, 1'b0, 1'b1, 128'h0020, 128'h0, 4'd7, 1'b1);
        run_op("both", 1'b1, 1'b1, 1'b1, 128'h0030, 128'h5555, 4'd1, 1'b0);
        run_op("sst", 1'b0, 1'b1, 1'b1, 128'h0040, 128'h1357_9BDF, 4'd4, 1'b0);

        // Reset during the second beat of a vector load
        bus.rmem    = 1'b1;
        bus.wmem    = 1'b0;
        bus.wreg    = 1'b1;
        bus.alu_res = 128'h0100;
        bus.vf      = 1'b1;
        @(negedge clk);
        chk("rstmid/issue_re", 128'(bus.mem_re), 128'(1));
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rstmid/stall",   128'(bus.stall),    128'(0));
        chk("rstmid/re",      128'(bus.mem_re),   128'(0));
        chk("rstmid/addr",    128'(bus.mem_addr), 128'(0));
        chk("rstmid/wb_wreg", 128'(bus.wb_wreg),  128'(0));
        chk("rstmid/wb_data", bus.wb_data,        128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid/hold_re", 128'(bus.mem_re), 128'(0));
            chk("rstmid/hold_we", 128'(bus.mem_we), 128'(0));
            next_cycle();
        end
        bus.rmem = 1'b0;
        rst      = 1'b0;
        exp_cnt  = 0;
        e_data   = '0;
        e_dest   = '0;
        e_vf     = 1'b0;
        run_op("post_rst_alu", 1'b0, 1'b0, 1'b1, 128'hCAFE_0042, 128'h0, 4'd11, 1'b0);

        // Randomized operation mix
        for (int i = 0; i < 80; i++) begin
            r_alu = {$urandom, $urandom, $urandom, $urandom};
            r_sd  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r_alu[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 0) r_alu[15:0] = 16'($urandom_range(0, 63));
            kind = $urandom_range(0, 5);
            case (kind)
                0: run_op("r_alu",  1'b0, 1'b0, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'($urandom));
                1: run_op("r_sld",  1'b1, 1'b0, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'b0);
                2: run_op("r_vld",  1'b1, 1'b0, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'b1);
                3: run_op("r_sst",  1'b0, 1'b1, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'b0);
                4: run_op("r_vst",  1'b0, 1'b1, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'b1);
                default: run_op("r_both", 1'b1, 1'b1, 1'($urandom), r_alu, r_sd, 4'($urandom), 1'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
